// File: rtl/reg_slice_pkg.sv
// Shared state encoding for the reg_slice_skid pipeline register slice.
package reg_slice_pkg;
    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } st_e;
endpackage

// File: rtl/dff_reg_ace.sv
// N-bit register with asynchronous active-high reset to INIT and a clock enable.
module dff_reg_ace #(
    parameter int           N    = 32,
    parameter logic [N-1:0] INIT = '0
) (
    input  logic         C,
    input  logic         R,
    input  logic         CE,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);
    always_ff @(posedge C or posedge R) begin
        if (R)       Q <= INIT;
        else if (CE) Q <= D;
    end
endmodule

// File: rtl/reg_slice_skid.sv
// Two-entry valid/ready skid buffer; all outputs come straight from flops.
// Optional FLUSH port and behaviour when REG_SLICE_FLUSH_EN is defined.
module reg_slice_skid
    import reg_slice_pkg::*;
#(
    parameter int           N    = 32,
    parameter logic [N-1:0] INIT = '0
) (
    input  logic         C,
    input  logic         R,
`ifdef REG_SLICE_FLUSH_EN
    input  logic         FLUSH,
`endif
    input  logic         S_VALID,
    output logic         S_READY,
    input  logic [N-1:0] S_DATA,
    output logic         M_VALID,
    input  logic         M_READY,
    output logic [N-1:0] M_DATA
);
    st_e          st_q, st_d;
    logic         s_ready_q, m_valid_q;
    logic         main_ce, skid_ce;
    logic [N-1:0] main_d, skid_q;
    logic         flush, s_fire, m_fire;

`ifdef REG_SLICE_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    assign s_fire  = S_VALID & s_ready_q;
    assign m_fire  = m_valid_q & M_READY;
    assign S_READY = s_ready_q;
    assign M_VALID = m_valid_q;

    always_comb begin
        st_d    = st_q;
        main_ce = 1'b0;
        skid_ce = 1'b0;
        main_d  = S_DATA;
        case (st_q)
            ST_EMPTY: if (s_fire) begin
                main_ce = 1'b1;
                st_d    = ST_BUSY;
            end
            ST_BUSY: begin
                if (s_fire && m_fire) begin
                    main_ce = 1'b1;
                end else if (s_fire) begin
                    skid_ce = 1'b1;
                    st_d    = ST_FULL;
                end else if (m_fire) begin
                    st_d    = ST_EMPTY;
                end
            end
            ST_FULL: if (m_fire) begin
                main_ce = 1'b1;
                main_d  = skid_q;
                st_d    = ST_BUSY;
            end
            default: st_d = ST_EMPTY;
        endcase
        // Flush drops everything but leaves the data registers untouched.
        if (flush) begin
            st_d    = ST_EMPTY;
            main_ce = 1'b0;
            skid_ce = 1'b0;
        end
    end

    // Ready/valid are registered from next state so no combinational path crosses the slice.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            st_q      <= ST_EMPTY;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            m_valid_q <= (st_d != ST_EMPTY);
            s_ready_q <= (st_d != ST_FULL);
        end
    end

    dff_reg_ace #(.N(N), .INIT(INIT)) u_main (
        .C(C), .R(R), .CE(main_ce), .D(main_d), .Q(M_DATA)
    );

    dff_reg_ace #(.N(N), .INIT(INIT)) u_skid (
        .C(C), .R(R), .CE(skid_ce), .D(S_DATA), .Q(skid_q)
    );
endmodule

// File: tb/tb_reg_slice_skid.sv
// Bench for reg_slice_skid: directed tasks plus a FIFO scoreboard monitor.
module tb_reg_slice_skid;
    localparam int N = 32;

    logic         C = 1'b0;
    logic         R = 1'b0;
    logic         FLUSH = 1'b0;
    logic         S_VALID = 1'b0;
    logic         S_READY;
    logic [N-1:0] S_DATA = '0;
    logic         M_VALID;
    logic         M_READY = 1'b0;
    logic [N-1:0] M_DATA;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [N-1:0] sb_q[$];

    always #5 C = ~C;

    reg_slice_skid #(.N(N), .INIT('0)) dut (
        .C(C), .R(R),
`ifdef REG_SLICE_FLUSH_EN
        .FLUSH(FLUSH),
`endif
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA)
    );

    // Scoreboard: inputs are stable at negedge and show what the next posedge will transfer.
    always @(negedge C) begin
        logic [N-1:0] exp;
        if (R) begin
            sb_q.delete();
        end else begin
            if (M_VALID === 1'b1 && M_READY) begin
                chk_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_order: got unexpected beat %h, required no beat", M_DATA);
                end else begin
                    exp = sb_q.pop_front();
                    if (M_DATA !== exp) $display("FAIL sb_order: got %h required %h", M_DATA, exp);
                    else pass_cnt++;
                end
            end
            if (FLUSH) sb_q.delete();
            else if (S_VALID && S_READY === 1'b1) sb_q.push_back(S_DATA);
        end
    end

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        #7 R = 1'b1;
        #1;
        chk_cnt++;
        if (M_VALID !== 1'b0 || S_READY !== 1'b0 || M_DATA !== '0)
            $display("FAIL reset_state: got v=%b r=%b d=%h required v=0 r=0 d=0", M_VALID, S_READY, M_DATA);
        else pass_cnt++;
        tick();
        #2 R = 1'b0;
        #1;
        chk_cnt++;
        if (S_READY !== 1'b0) $display("FAIL reset_release_pre: got %b required 0", S_READY);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (S_READY !== 1'b1 || M_VALID !== 1'b0)
            $display("FAIL reset_release_post: got r=%b v=%b required r=1 v=0", S_READY, M_VALID);
        else pass_cnt++;
    endtask

    task automatic test_single();
        M_READY = 1'b1;
        S_DATA  = 32'hA5A5_0001;
        S_VALID = 1'b1;
        tick();
        S_VALID = 1'b0;
        chk_cnt++;
        if (M_VALID !== 1'b1 || M_DATA !== 32'hA5A5_0001)
            $display("FAIL single_out: got v=%b d=%h required v=1 d=a5a50001", M_VALID, M_DATA);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (M_VALID !== 1'b0) $display("FAIL single_once: got v=%b required 0", M_VALID);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        M_READY = 1'b0;
        S_VALID = 1'b1;
        S_DATA  = 32'h11;
        tick();
        S_DATA = 32'h22;
        tick();
        S_DATA = 32'h33;
        chk_cnt++;
        if (S_READY !== 1'b0 || M_VALID !== 1'b1 || M_DATA !== 32'h11)
            $display("FAIL bp_full: got r=%b v=%b d=%h required r=0 v=1 d=11", S_READY, M_VALID, M_DATA);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (S_READY !== 1'b0 || M_DATA !== 32'h11)
            $display("FAIL bp_hold: got r=%b d=%h required r=0 d=11", S_READY, M_DATA);
        else pass_cnt++;
        M_READY = 1'b1;
        tick();
        chk_cnt++;
        if (M_VALID !== 1'b1 || M_DATA !== 32'h22 || S_READY !== 1'b1)
            $display("FAIL bp_drain1: got v=%b r=%b d=%h required v=1 r=1 d=22", M_VALID, S_READY, M_DATA);
        else pass_cnt++;
        tick();
        S_VALID = 1'b0;
        chk_cnt++;
        if (M_VALID !== 1'b1 || M_DATA !== 32'h33)
            $display("FAIL bp_drain2: got v=%b d=%h required v=1 d=33", M_VALID, M_DATA);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (M_VALID !== 1'b0) $display("FAIL bp_empty: got v=%b required 0", M_VALID);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        int sent = 0;
        int cyc  = 0;
        M_READY = 1'b1;
        S_VALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
            S_DATA = N'(i);
            tick();
            chk_cnt++;
            if (M_VALID !== 1'b1 || M_DATA !== N'(i) || S_READY !== 1'b1)
                $display("FAIL stream_beat%0d: got v=%b r=%b d=%h required v=1 r=1 d=%h",
                         i, M_VALID, S_READY, M_DATA, N'(i));
            else pass_cnt++;
        end
        S_VALID = 1'b0;
        tick();
        // Random backpressure; the producer holds each beat until it is taken.
        while (sent < 60 && cyc < 2000) begin
            S_VALID = 1'b1;
            S_DATA  = N'(1000 + sent);
            M_READY = 1'($urandom_range(0, 1));
            if (S_READY === 1'b1) sent++;
            tick();
            cyc++;
        end
        S_VALID = 1'b0;
        M_READY = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        chk_cnt++;
        if (sent != 60 || sb_q.size() != 0 || M_VALID !== 1'b0)
            $display("FAIL stream_random_drain: got sent=%0d left=%0d v=%b required sent=60 left=0 v=0",
                     sent, sb_q.size(), M_VALID);
        else pass_cnt++;
    endtask

    task automatic test_reset_full();
        M_READY = 1'b0;
        S_VALID = 1'b1;
        S_DATA  = 32'hAA;
        tick();
        S_DATA = 32'hBB;
        tick();
        S_VALID = 1'b0;
        #2 R = 1'b1;
        #1;
        chk_cnt++;
        if (M_VALID !== 1'b0 || S_READY !== 1'b0 || M_DATA !== '0)
            $display("FAIL rst_full_now: got v=%b r=%b d=%h required v=0 r=0 d=0", M_VALID, S_READY, M_DATA);
        else pass_cnt++;
        tick();
        #2 R = 1'b0;
        M_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if (M_VALID !== 1'b0 || S_READY !== 1'b1)
                $display("FAIL rst_full_stale%0d: got v=%b r=%b required v=0 r=1", i, M_VALID, S_READY);
            else pass_cnt++;
        end
    endtask

`ifdef REG_SLICE_FLUSH_EN
    task automatic test_flush();
        M_READY = 1'b0;
        S_VALID = 1'b1;
        S_DATA  = 32'h55;
        tick();
        S_DATA = 32'h66;
        tick();
        S_DATA = 32'h77;
        FLUSH  = 1'b1;
        tick();
        FLUSH   = 1'b0;
        S_VALID = 1'b0;
        chk_cnt++;
        if (M_VALID !== 1'b0 || S_READY !== 1'b1)
            $display("FAIL flush_empty: got v=%b r=%b required v=0 r=1", M_VALID, S_READY);
        else pass_cnt++;
        M_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if (M_VALID !== 1'b0) $display("FAIL flush_no77_%0d: got v=%b d=%h required v=0", i, M_VALID, M_DATA);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_reset_full();
`ifdef REG_SLICE_FLUSH_EN
        test_flush();
`endif
        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
